// File: rtl/global_broadcast_unpool.sv
// Replays one pooled 7-channel vector as a full IMG_WIDTH x IMG_HEIGHT pixel stream.
// A one-vector skid slot lets the next map start on the cycle after the previous map's final beat.
module global_broadcast_unpool #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDTH  = 34,
  parameter int IMG_HEIGHT = 34,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDHT*7-1:0] Data_In,
  input  logic                    Valid_In,
  output logic                    Ready_In,
  output logic [DATA_WIDHT*7-1:0] Data_Out,
  output logic                    Valid_Out,
  input  logic                    Ready_Out,
  output logic                    Last_Out,
  output logic                    Row_End
);

  localparam int VEC_W = DATA_WIDHT * 7;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] PIX_LAST = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]     COL_LAST = COL_W'(IMG_WIDTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state, state_nxt;
  logic [VEC_W-1:0]     active_reg, pend_reg;
  logic                 pend_vld;
  logic [CNT_WIDTH-1:0] pix_cnt;
  logic [COL_W-1:0]     col_cnt;

  logic accept, beat, final_beat;

  assign Ready_In   = ~pend_vld;
  assign accept     = Valid_In & Ready_In;
  assign beat       = Valid_Out & Ready_Out;
  assign final_beat = beat & (pix_cnt == PIX_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = STREAM;
      STREAM: if (final_beat && !pend_vld && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Valid_Out = (state == STREAM);
    Data_Out  = Valid_Out ? active_reg : '0;
    Last_Out  = Valid_Out & (pix_cnt == PIX_LAST);
    Row_End   = Valid_Out & (col_cnt == COL_LAST);
  end

  // Counters and the slot flag carry control meaning, so they clear asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      col_cnt  <= '0;
      pend_vld <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        pix_cnt <= '0;
        col_cnt <= '0;
      end
    end else begin
      if (final_beat) begin
        pix_cnt  <= '0;
        col_cnt  <= '0;
        pend_vld <= 1'b0;
      end else begin
        if (beat) begin
          pix_cnt <= pix_cnt + CNT_WIDTH'(1);
          col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + COL_W'(1);
        end
        if (accept) pend_vld <= 1'b1;
      end
    end
  end

  // NOTE: vector storage is not reset; Data_Out is gated by Valid_Out so stale contents never leak.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (accept) active_reg <= Data_In;
    end else if (final_beat) begin
      if (pend_vld)    active_reg <= pend_reg;
      else if (accept) active_reg <= Data_In;
    end else if (accept) begin
      pend_reg <= Data_In;
    end
  end

endmodule

// File: doc/global_broadcast_unpool.md
Name: global_broadcast_unpool

Overview:
- Inverse of the global-average-pooling stage: takes one 7-channel FP32 vector and replays it as a full IMG_WIDTH x IMG_HEIGHT pixel stream.
- Each output beat carries the same 7 channel words, so downstream per-pixel layers receive a spatially constant feature map.
- Sits after the pooled-feature path (broadcast / skip-merge / backward distribution).
- Has a valid/ready handshake on both sides and a one-vector skid slot, so back-to-back vectors stream without bubbles.

Parameters:
- DATA_WIDHT, 32: width of one channel word (FP32 bit pattern, passed through untouched).
- IMG_WIDTH, 34: output map width in pixels.
- IMG_HEIGHT, 34: output map height in pixels.
- CNT_WIDTH, 11: pixel counter width. Must satisfy 2^CNT_WIDTH >= IMG_WIDTH*IMG_HEIGHT (1156 for the defaults).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Data_In  input  DATA_WIDHT*7  channel vector; channel k occupies bits [DATA_WIDHT*(k+1)-1 : DATA_WIDHT*k].
- Valid_In  input  1  Data_In is valid.
- Ready_In  output  1  block can accept a vector this cycle.
- Data_Out  output  DATA_WIDHT*7  broadcast vector, same channel packing as Data_In.
- Valid_Out  output  1  Data_Out is valid.
- Ready_Out  input  1  downstream accepts the beat.
- Last_Out  output  1  current beat is the final pixel of the map.
- Row_End  output  1  current beat is the last pixel of a row.

Behaviour:
- Transfer rules:
  - Input accept = Valid_In & Ready_In.
  - Output beat = Valid_Out & Ready_Out.
  - All state updates on posedge clk only.
- Storage:
  - active_reg: the vector being streamed.
  - pend_reg plus pend_vld: the skid slot.
  - pix_cnt (CNT_WIDTH bits) and col_cnt.
- Reset (async, rst=1), effective immediately and mid-stream: state=IDLE, pix_cnt=0, col_cnt=0, pend_vld=0, Valid_Out=0, Last_Out=0, Row_End=0, Data_Out=0, Ready_In=1 while rst is high. Any partially streamed map is discarded; nothing resumes after reset release.
- Ready_In = ~pend_vld (combinational from a register). It is 1 in IDLE and 1 in STREAM while the skid slot is empty.
- State machine:
  - IDLE: Valid_Out=0. On input accept: active_reg<=Data_In, pix_cnt<=0, col_cnt<=0, go to STREAM. The first Valid_Out is asserted the next cycle, giving 1-cycle latency.
  - STREAM: Valid_Out=1 and Data_Out=active_reg, both held stable while Ready_Out=0.
    - On an output beat: pix_cnt+1; col_cnt+1, wrapping to 0 at IMG_WIDTH-1.
    - Input accept in STREAM with pend_vld=0 and not the final beat: pend_reg<=Data_In, pend_vld<=1.
  - Final beat (output beat with pix_cnt==N-1, where N=IMG_WIDTH*IMG_HEIGHT):
    - If pend_vld=1: active_reg<=pend_reg, pend_vld<=0, counters<=0, stay in STREAM (no bubble).
    - Else if an input accept occurs in the same cycle: active_reg<=Data_In directly, counters<=0, stay in STREAM.
    - Else: go to IDLE; Valid_Out=0 next cycle.
  - Simultaneous final beat + pend_vld=1 + Valid_In: Ready_In is 0, so the input is not taken that cycle. It is accepted next cycle into the freed slot.
- Output flags (combinational from counters, qualified by Valid_Out):
  - Last_Out = Valid_Out & (pix_cnt==N-1).
  - Row_End = Valid_Out & (col_cnt==IMG_WIDTH-1).
- Exactly N output beats per accepted vector. Vectors are emitted in acceptance order; none is dropped or duplicated.
- Data is not interpreted: no FP arithmetic, and bit patterns (including NaN/denormal) pass verbatim.
- Throughput: 1 beat/cycle when Ready_Out=1; sustained back-to-back maps with zero idle cycles.

Test Plan:
- Single vector: reset, then Valid_In one cycle with channels 0..6 = 32'h3F800000..32'h40E00000, Ready_Out=1 held.
  - Required: Valid_Out rises 1 cycle after accept, 1156 consecutive identical beats.
  - Row_End on beats 33, 67, ..., 1155; Last_Out only on beat 1155; IDLE afterwards.
- Backpressure: Ready_Out toggled by a random 50% pattern during a map.
  - Required: Data_Out/Valid_Out stable while stalled; still exactly 1156 beats.
- Back-to-back: vector A accepted, then vector B offered at beat 10 (Ready_In=1, B taken into the slot), then vector C offered.
  - Required: Ready_In=0 until A's final beat; B's first beat immediately follows A's last beat with no gap.
  - Then C is accepted, giving order A, B, C.
- Same-cycle handoff: skid slot empty; new vector presented exactly on the final beat.
  - Required: it is accepted and streams from the next cycle with no bubble.
- Reset mid-stream: assert rst at beat 500 with the skid slot full.
  - Required: outputs 0 immediately and the pending vector is lost.
  - After release, a new vector produces a fresh 1156-beat map from pix_cnt=0.
- Small-geometry parameter check: IMG_WIDTH=3, IMG_HEIGHT=2, CNT_WIDTH=3.
  - Required: 6 beats, Row_End on beats 2 and 5, Last_Out on beat 5.
